// File: rtl/rate_scheduler.sv
// rate_scheduler: time-multiplexed fractional-rate tick generator.
// One shared accumulator datapath visits the channels in turn (slot pointer
// slt). Each channel emits a one-cycle tick at an average rate of
// (add+1)/(max+1) per visit.
// Optional feature macro: RATE_SCHEDULER_CFG_ERR_EN adds an err output that
// flags (and drops) configurations with add > max. Without the macro, such
// configurations have add saturated to max.

module rate_scheduler #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        run,
    input  logic                        cfg_vld,
    output logic                        cfg_rdy,
    input  logic [$clog2(CHANNELS)-1:0] cfg_ch,
    input  logic                        cfg_ena,
    input  logic [WIDTH-1:0]            cfg_add,
    input  logic [WIDTH-1:0]            cfg_max,
    output logic [CHANNELS-1:0]         tck,
`ifdef RATE_SCHEDULER_CFG_ERR_EN
    output logic                        err,
`endif
    output logic [$clog2(CHANNELS)-1:0] slt
);

    localparam int SW = $clog2(CHANNELS);
    localparam logic [SW-1:0] LAST_SLOT = SW'(CHANNELS - 1);
    localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);

    logic [SW-1:0]       slt_q, slt_d;
    logic [CHANNELS-1:0] ena_q, ena_d;
    logic [CHANNELS-1:0] tck_q, tck_d;
    logic [WIDTH-1:0]    add_q [CHANNELS];
    logic [WIDTH-1:0]    add_d [CHANNELS];
    logic [WIDTH-1:0]    max_q [CHANNELS];
    logic [WIDTH-1:0]    max_d [CHANNELS];
    logic [WIDTH-1:0]    acc_q [CHANNELS];
    logic [WIDTH-1:0]    acc_d [CHANNELS];

    logic [WIDTH:0]      sum;
    logic [WIDTH-1:0]    wrap_acc;
    logic                wrap;
    logic                xfer;

`ifdef RATE_SCHEDULER_CFG_ERR_EN
    logic                err_q, err_d;
    assign err = err_q;
`endif

    // A config write is refused only when it targets the channel the shared
    // adder is updating this cycle; any other channel can be written freely.
    assign cfg_rdy = !(run && (cfg_ch == slt_q));
    assign xfer    = cfg_vld && cfg_rdy;
    assign tck     = tck_q;
    assign slt     = slt_q;

    // Shared adder for the slot currently addressed; one bit wider so the
    // wrap test cannot overflow.
    always_comb begin
        sum      = {1'b0, acc_q[slt_q]} + {1'b0, add_q[slt_q]} + ONE;
        wrap     = sum > {1'b0, max_q[slt_q]};
        wrap_acc = WIDTH'(sum - {1'b0, max_q[slt_q]} - ONE);
    end

    // Next-state: advance slot, update the visited channel, then apply any
    // config write (never to the visited channel, since cfg_rdy blocks that).
    always_comb begin
        slt_d = slt_q;
        ena_d = ena_q;
        add_d = add_q;
        max_d = max_q;
        acc_d = acc_q;
        tck_d = '0;
`ifdef RATE_SCHEDULER_CFG_ERR_EN
        err_d = 1'b0;
`endif
        if (run) begin
            slt_d = (slt_q == LAST_SLOT) ? '0 : slt_q + 1'b1;
            if (ena_q[slt_q]) begin
                if (wrap) begin
                    acc_d[slt_q] = wrap_acc;
                    tck_d[slt_q] = 1'b1;
                end else begin
                    acc_d[slt_q] = sum[WIDTH-1:0];
                end
            end
        end
        if (xfer) begin
`ifdef RATE_SCHEDULER_CFG_ERR_EN
            if (cfg_add > cfg_max) begin
                err_d = 1'b1;
            end else begin
                ena_d[cfg_ch] = cfg_ena;
                add_d[cfg_ch] = cfg_add;
                max_d[cfg_ch] = cfg_max;
                acc_d[cfg_ch] = '0;
            end
`else
            ena_d[cfg_ch] = cfg_ena;
            add_d[cfg_ch] = (cfg_add > cfg_max) ? cfg_max : cfg_add;
            max_d[cfg_ch] = cfg_max;
            acc_d[cfg_ch] = '0;
`endif
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slt_q <= '0;
            ena_q <= '0;
            tck_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                add_q[i] <= '0;
                max_q[i] <= '0;
                acc_q[i] <= '0;
            end
`ifdef RATE_SCHEDULER_CFG_ERR_EN
            err_q <= 1'b0;
`endif
        end else begin
            slt_q <= slt_d;
            ena_q <= ena_d;
            tck_q <= tck_d;
            add_q <= add_d;
            max_q <= max_d;
            acc_q <= acc_d;
`ifdef RATE_SCHEDULER_CFG_ERR_EN
            err_q <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_rate_scheduler.sv
// Directed testbench for rate_scheduler (WIDTH=4, CHANNELS=4). Builds with or
// without RATE_SCHEDULER_CFG_ERR_EN.

module tb_rate_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       cfg_vld;
    logic       cfg_rdy;
    logic [1:0] cfg_ch;
    logic       cfg_ena;
    logic [3:0] cfg_add;
    logic [3:0] cfg_max;
    logic [3:0] tck;
    logic [1:0] slt;
`ifdef RATE_SCHEDULER_CFG_ERR_EN
    logic       err;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         m_acc [4];
    int         m_add [4];
    int         m_max [4];
    logic [3:0] m_ena;
    int         m_slt;
    logic [3:0] m_tck;
    logic       m_err;
    logic       m_rdy;

    always #5 clk = ~clk;

    rate_scheduler #(.WIDTH(4), .CHANNELS(4)) dut (
        .clk(clk),
        .rst(rst),
        .run(run),
        .cfg_vld(cfg_vld),
        .cfg_rdy(cfg_rdy),
        .cfg_ch(cfg_ch),
        .cfg_ena(cfg_ena),
        .cfg_add(cfg_add),
        .cfg_max(cfg_max),
        .tck(tck),
`ifdef RATE_SCHEDULER_CFG_ERR_EN
        .err(err),
`endif
        .slt(slt)
    );

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_acc[i] = 0;
            m_add[i] = 0;
            m_max[i] = 0;
        end
        m_ena = '0;
        m_slt = 0;
        m_tck = '0;
        m_err = 1'b0;
    endtask

    task automatic model_edge();
        int s;
        int ch;
        m_rdy = !(run && (int'(cfg_ch) == m_slt));
        m_tck = '0;
        m_err = 1'b0;
        if (run) begin
            if (m_ena[m_slt]) begin
                s = m_acc[m_slt] + m_add[m_slt] + 1;
                if (s > m_max[m_slt]) begin
                    m_tck[m_slt] = 1'b1;
                    m_acc[m_slt] = s - (m_max[m_slt] + 1);
                end else begin
                    m_acc[m_slt] = s;
                end
            end
            m_slt = (m_slt + 1) % 4;
        end
        if (cfg_vld && m_rdy) begin
            ch = int'(cfg_ch);
`ifdef RATE_SCHEDULER_CFG_ERR_EN
            if (cfg_add > cfg_max) begin
                m_err = 1'b1;
            end else begin
                m_ena[ch] = cfg_ena;
                m_add[ch] = int'(cfg_add);
                m_max[ch] = int'(cfg_max);
                m_acc[ch] = 0;
            end
`else
            m_ena[ch] = cfg_ena;
            m_add[ch] = (cfg_add > cfg_max) ? int'(cfg_max) : int'(cfg_add);
            m_max[ch] = int'(cfg_max);
            m_acc[ch] = 0;
`endif
        end
    endtask

    // One active edge; inputs are driven and outputs sampled at negedges.
    task automatic cycle();
        if (!rst) model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        run     = 1'b0;
        cfg_vld = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic configure(input int ch, input logic e, input int a, input int m);
        run     = 1'b0;
        cfg_vld = 1'b1;
        cfg_ch  = 2'(ch);
        cfg_ena = e;
        cfg_add = 4'(a);
        cfg_max = 4'(m);
        cycle();
        cfg_vld = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        run     = 1'b0;
        cfg_vld = 1'b0;
        cfg_ch  = 2'd0;
        model_clear();
        @(negedge clk);
        checks++;
        if (slt !== 2'd0) begin errors++; $display("[TB] FAIL reset_slt: got %0d expected 0", slt); end
        checks++;
        if (tck !== 4'b0000) begin errors++; $display("[TB] FAIL reset_tck: got %b expected 0000", tck); end
        checks++;
        if (cfg_rdy !== 1'b1) begin errors++; $display("[TB] FAIL reset_rdy_idle: got %b expected 1", cfg_rdy); end
`ifdef RATE_SCHEDULER_CFG_ERR_EN
        checks++;
        if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
`endif
        run = 1'b1;
        #1;
        checks++;
        if (cfg_rdy !== 1'b0) begin errors++; $display("[TB] FAIL reset_rdy_collide: got %b expected 0", cfg_rdy); end
        run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_channel();
        logic [3:0] exp;
        do_reset();
        configure(0, 1'b1, 0, 3);
        run = 1'b1;
        for (int i = 1; i <= 66; i++) begin
            cycle();
            exp = (i >= 13 && (i - 13) % 16 == 0) ? 4'b0001 : 4'b0000;
            checks++;
            if (tck !== exp) begin errors++; $display("[TB] FAIL ch0_tick edge %0d: got %b expected %b", i, tck, exp); end
            checks++;
            if (slt !== 2'(i % 4)) begin errors++; $display("[TB] FAIL ch0_slot edge %0d: got %0d expected %0d", i, slt, i % 4); end
        end
        run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (slt !== 2'd2) begin errors++; $display("[TB] FAIL hold_slot: got %0d expected 2", slt); end
            checks++;
            if (tck !== 4'b0000) begin errors++; $display("[TB] FAIL hold_tick: got %b expected 0000", tck); end
        end
    endtask

    task automatic test_fractional();
        logic [4:0] pat;
        logic [3:0] exp;
        pat = 5'b11010;
        do_reset();
        configure(1, 1'b1, 2, 4);
        run = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            cycle();
            exp = 4'b0000;
            if (i % 4 == 2 && pat[((i - 2) / 4) % 5]) exp = 4'b0010;
            checks++;
            if (tck !== exp) begin errors++; $display("[TB] FAIL ch1_frac edge %0d: got %b expected %b", i, tck, exp); end
        end
    endtask

    task automatic test_extremes();
        logic [3:0] exp;
        do_reset();
        configure(2, 1'b1, 15, 15);
        configure(3, 1'b1, 0, 15);
        run = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            cycle();
            exp = 4'b0000;
            if (i % 4 == 3) exp[2] = 1'b1;
            if (i == 64) exp[3] = 1'b1;
            checks++;
            if (tck !== exp) begin errors++; $display("[TB] FAIL extremes edge %0d: got %b expected %b", i, tck, exp); end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_tbl [22];
        exp_tbl = '{4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h2, 4'h4, 4'h0, 4'h0, 4'h0, 4'h4,
                    4'h0, 4'h1, 4'h2, 4'h4, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h2};
        do_reset();
        configure(0, 1'b1, 0, 3);
        configure(1, 1'b1, 2, 4);
        configure(2, 1'b1, 15, 15);
        run = 1'b1;
        for (int i = 1; i <= 22; i++) begin
            if (i == 6) begin
                cfg_vld = 1'b1;
                cfg_ch  = 2'd1;
                cfg_ena = 1'b1;
                cfg_add = 4'd2;
                cfg_max = 4'd4;
                #1;
                checks++;
                if (slt !== 2'd1) begin errors++; $display("[TB] FAIL collide_slot: got %0d expected 1", slt); end
                checks++;
                if (cfg_rdy !== 1'b0) begin errors++; $display("[TB] FAIL collide_rdy_low: got %b expected 0", cfg_rdy); end
            end
            if (i == 7) begin
                #1;
                checks++;
                if (cfg_rdy !== 1'b1) begin errors++; $display("[TB] FAIL collide_rdy_high: got %b expected 1", cfg_rdy); end
            end
            cycle();
            if (i == 7) cfg_vld = 1'b0;
            checks++;
            if (tck !== exp_tbl[i-1]) begin errors++; $display("[TB] FAIL collide_tick edge %0d: got %b expected %b", i, tck, exp_tbl[i-1]); end
        end
    endtask

    task automatic test_saturate();
        logic [3:0] exp;
        do_reset();
`ifdef RATE_SCHEDULER_CFG_ERR_EN
        configure(0, 1'b1, 0, 3);
        configure(0, 1'b1, 5, 3);
        checks++;
        if (err !== 1'b1) begin errors++; $display("[TB] FAIL err_pulse: got %b expected 1", err); end
        cycle();
        checks++;
        if (err !== 1'b0) begin errors++; $display("[TB] FAIL err_clear: got %b expected 0", err); end
`else
        configure(0, 1'b1, 5, 3);
`endif
        run = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            cycle();
`ifdef RATE_SCHEDULER_CFG_ERR_EN
            exp = (i == 13) ? 4'b0001 : 4'b0000;
            checks++;
            if (err !== 1'b0) begin errors++; $display("[TB] FAIL err_idle edge %0d: got %b expected 0", i, err); end
`else
            exp = (i % 4 == 1) ? 4'b0001 : 4'b0000;
`endif
            checks++;
            if (tck !== exp) begin errors++; $display("[TB] FAIL saturate edge %0d: got %b expected %b", i, tck, exp); end
        end
    endtask

    task automatic rand_drive();
        run = ($urandom_range(0, 3) != 0);
        if (!cfg_vld && $urandom_range(0, 2) == 0) begin
            cfg_vld = 1'b1;
            cfg_ch  = 2'($urandom_range(0, 3));
            cfg_ena = ($urandom_range(0, 3) != 0);
            cfg_max = 4'($urandom_range(0, 15));
            cfg_add = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                  : 4'($urandom_range(0, int'(cfg_max)));
        end
    endtask

    task automatic random_phase(input int n, input string tag);
        logic exp_rdy;
        for (int i = 0; i < n; i++) begin
            rand_drive();
            #1;
            exp_rdy = !(run && (int'(cfg_ch) == m_slt));
            checks++;
            if (cfg_rdy !== exp_rdy) begin errors++; $display("[TB] FAIL %s_rdy cyc %0d: got %b expected %b", tag, i, cfg_rdy, exp_rdy); end
            cycle();
            if (cfg_vld && m_rdy) cfg_vld = 1'b0;
            checks++;
            if (tck !== m_tck) begin errors++; $display("[TB] FAIL %s_tick cyc %0d: got %b expected %b", tag, i, tck, m_tck); end
            checks++;
            if (slt !== 2'(m_slt)) begin errors++; $display("[TB] FAIL %s_slot cyc %0d: got %0d expected %0d", tag, i, slt, m_slt); end
`ifdef RATE_SCHEDULER_CFG_ERR_EN
            checks++;
            if (err !== m_err) begin errors++; $display("[TB] FAIL %s_err cyc %0d: got %b expected %b", tag, i, err, m_err); end
`endif
        end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        configure(0, 1'b1, 3, 7);
        configure(1, 1'b1, 1, 2);
        configure(2, 1'b1, 6, 9);
        configure(3, 1'b1, 0, 1);
        random_phase(41, "pre");
        #2;
        rst     = 1'b1;
        cfg_vld = 1'b0;
        #1;
        model_clear();
        checks++;
        if (tck !== 4'b0000) begin errors++; $display("[TB] FAIL midrst_tick: got %b expected 0000", tck); end
        checks++;
        if (slt !== 2'd0) begin errors++; $display("[TB] FAIL midrst_slot: got %0d expected 0", slt); end
`ifdef RATE_SCHEDULER_CFG_ERR_EN
        checks++;
        if (err !== 1'b0) begin errors++; $display("[TB] FAIL midrst_err: got %b expected 0", err); end
`endif
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        random_phase(96, "post");
    endtask

    initial begin
        rst     = 1'b1;
        run     = 1'b0;
        cfg_vld = 1'b0;
        cfg_ch  = 2'd0;
        cfg_ena = 1'b0;
        cfg_add = 4'd0;
        cfg_max = 4'd0;
        test_reset();
        test_single_channel();
        test_fractional();
        test_extremes();
        test_back_to_back();
        test_saturate();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
